stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Timekeeping stage of the stopwatch: holds the MM:SS count in BCD, advances it from one-cycle tick enables, handles pause and the adjust mode, and produces the four registered active-low seven-segment patterns that the display scan stage multiplexes onto the anodes. All timing derives from single-cycle enables generated by the clock-divider stage, so the block runs entirely in the one system clock domain.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle enable pulse at 1 Hz; drives normal counting.
- `tick_2hz`  in  1  one-cycle enable pulse at 2 Hz; drives adjust stepping.
- `blink`  in  1  level, ~50% duty, a few Hz; blanks the field being adjusted.
- `pause`  in  1  debounced one-cycle pulse; toggles run/pause.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; in adjust mode, 0 = minutes, 1 = seconds.
- `seg_min_top`, `seg_min_bot`, `seg_sec_top`, `seg_sec_bot`  out  8 each  registered segment patterns for minute tens, minute ones, second tens and second ones.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  registered BCD count digits.
- `paused`  out  1  registered run/pause state; 1 = frozen.

## Operation
- Count range 00:00 to 99:59. Digits stay in legal BCD: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-9.
- Run/pause: a two-state FSM, RUN (`paused`=0) and PAUSE (`paused`=1). A `pause` pulse toggles the state. It applies in both modes.
- Normal mode (`adj`=0, RUN): each `tick_1hz` increments seconds with a ripple carry.
  - 59 -> 00 carries +1 into minutes.
  - 99:59 -> 00:00 (full wrap).
  - `tick_2hz` is ignored.
- Adjust mode (`adj`=1, RUN): normal counting stops and `tick_1hz` is ignored. Each `tick_2hz` steps the selected field by 1.
  - `sel`=1: seconds 59 -> 00, with no carry into minutes.
  - `sel`=0: minutes 99 -> 00; seconds are unchanged.
- PAUSE: no tick changes the count in either mode.
- Segment encoding:
  - Bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a; active-low; dp is always 1 (off).
  - Digits 0-9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex). Blank = FF.
- Blinking: when `adj`=1 and `blink`=1, both digits of the selected field output FF. The unselected field and all BCD outputs are unaffected. When `adj`=0, nothing blanks.
- Simultaneous events:
  - `rst` overrides everything.
  - When `pause` and a tick land in the same cycle, the tick is evaluated against the pre-toggle state. RUN + `pause` + tick: the count advances and then the block pauses. PAUSE + `pause` + tick: no advance, then the block runs.
  - A mode or `sel` change takes effect in the cycle it is sampled; no step is lost or doubled beyond what that rule implies.

## Timing
- Reset (synchronous): count 00:00, `paused`=0 (RUN), BCD outputs 0, all four `seg_*` = C0. These values are visible after the first rising edge with `rst`=1.
- Count registers update on the edge that samples the tick. BCD outputs are those registers, so latency is 1 cycle from the tick.
- `seg_*` outputs are registered from the count and blink state. Latency is 2 cycles from the tick and 1 cycle from a `blink`, `adj` or `sel` change.
- `paused` updates on the edge that samples `pause`.
- Ticks are assumed to be single-cycle. A tick held high N cycles counts N times; this is not guarded.

## Test plan
- Reset then run:
  - Stimulus: `rst` for 1 cycle.
  - Required: BCD 00:00, all `seg_*`=C0, `paused`=0.
  - Stimulus: 61 `tick_1hz` pulses.
  - Required: 01:01; `seg_min_bot`=F9 and `seg_sec_bot`=F9 two cycles after the last tick.
- Full wrap:
  - Stimulus: drive the count to 99:59 via adjust, return to normal, one `tick_1hz`.
  - Required: 00:00 next cycle; all `seg_*`=C0 one cycle later.
- Pause:
  - Stimulus: at 00:05 pulse `pause`, then 10 `tick_1hz`.
  - Required: stays 00:05, `paused`=1.
  - Stimulus: pulse `pause` coincident with a tick.
  - Required: no advance, then `paused`=0; the next tick gives 00:06.
- Adjust seconds:
  - Stimulus: `adj`=1, `sel`=1 at 03:58; 3 `tick_2hz` plus interleaved `tick_1hz`.
  - Required: 03:59, 03:00, 03:01; minutes stay 3; `tick_1hz` has no effect.
- Adjust minutes and blink:
  - Stimulus: `adj`=1, `sel`=0, count 98:30; 2 `tick_2hz`.
  - Required: 99:30 then 00:30, seconds untouched.
  - Stimulus: `blink`=1.
  - Required: `seg_min_top`/`seg_min_bot`=FF; `seg_sec_top`=B0, `seg_sec_bot`=C0.
  - Stimulus: `blink`=0.
  - Required: `seg_min_*`=C0/C0.
- Reset mid-operation:
  - Stimulus: in adjust mode with PAUSE at 42:17, assert `rst` together with a `tick_2hz` and a `pause` pulse.
  - Required: 00:00, `paused`=0, all `seg_*`=C0.

Source files
------------

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_core
//  Purpose  : MM:SS BCD timekeeping for the stopwatch. Counts on 1 Hz enables,
//             steps a selected field on 2 Hz enables in adjust mode, toggles
//             run/pause, and drives four registered active-low seven-segment
//             patterns (dp off) with blinking of the field being adjusted.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       blink,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg_min_top,
  output logic [7:0] seg_min_bot,
  output logic [7:0] seg_sec_top,
  output logic [7:0] seg_sec_bot,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused
);

  // Segment patterns: bit 7 = dp, bits 6..0 = g..a, active-low.
  localparam logic [7:0] C_SEG_BLANK = 8'hFF;
  localparam logic [7:0] C_SEG_ZERO  = 8'hC0;

  // Legal BCD limits of each digit.
  localparam logic [3:0] C_DEC_MAX = 4'd9;
  localparam logic [3:0] C_SEX_MAX = 4'd5;

  // Run/pause state.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  state_t r_state;

  // Step requests, all qualified by the pre-toggle run state so that a pause
  // pulse coincident with a tick is judged against the state before it.
  logic w_run;
  logic w_norm_step;
  logic w_adj_sec_step;
  logic w_adj_min_step;
  logic w_sec_inc;
  logic w_min_inc;

  // Carry detection on the current count.
  logic w_sec_ones_max;
  logic w_sec_at_max;
  logic w_min_ones_max;

  // Next-state count digits.
  logic [3:0] w_sec_ones_nxt;
  logic [3:0] w_sec_tens_nxt;
  logic [3:0] w_min_ones_nxt;
  logic [3:0] w_min_tens_nxt;

  // Field blanking for the display path.
  logic w_blank_min;
  logic w_blank_sec;

  // BCD digit to active-low seven-segment pattern; illegal codes blank.
  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = C_SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Run/pause FSM with registered paused flag; a pause pulse toggles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      paused  <= 1'b0;
    end else if (pause) begin
      case (r_state)
        ST_RUN: begin
          r_state <= ST_PAUSE;
          paused  <= 1'b1;
        end
        ST_PAUSE: begin
          r_state <= ST_RUN;
          paused  <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          paused  <= 1'b0;
        end
      endcase
    end
  end

  // Decode which field, if any, advances this cycle.
  always_comb begin
    w_run          = (r_state == ST_RUN);
    w_norm_step    = w_run & ~adj & tick_1hz;
    w_adj_sec_step = w_run &  adj &  sel & tick_2hz;
    w_adj_min_step = w_run &  adj & ~sel & tick_2hz;

    w_sec_ones_max = (sec_ones == C_DEC_MAX);
    w_sec_at_max   = w_sec_ones_max & (sec_tens == C_SEX_MAX);
    w_min_ones_max = (min_ones == C_DEC_MAX);

    // Seconds carry into minutes only during normal counting.
    w_sec_inc = w_norm_step | w_adj_sec_step;
    w_min_inc = (w_norm_step & w_sec_at_max) | w_adj_min_step;
  end

  // Next seconds digits: 0-9 ones, 0-5 tens, wrapping 59 -> 00.
  always_comb begin
    w_sec_ones_nxt = sec_ones;
    w_sec_tens_nxt = sec_tens;
    if (w_sec_inc) begin
      if (w_sec_ones_max) begin
        w_sec_ones_nxt = 4'd0;
        w_sec_tens_nxt = (sec_tens >= C_SEX_MAX) ? 4'd0 : sec_tens + 4'd1;
      end else begin
        w_sec_ones_nxt = sec_ones + 4'd1;
      end
    end
  end

  // Next minutes digits: 0-9 each, wrapping 99 -> 00.
  always_comb begin
    w_min_ones_nxt = min_ones;
    w_min_tens_nxt = min_tens;
    if (w_min_inc) begin
      if (w_min_ones_max) begin
        w_min_ones_nxt = 4'd0;
        w_min_tens_nxt = (min_tens >= C_DEC_MAX) ? 4'd0 : min_tens + 4'd1;
      end else begin
        w_min_ones_nxt = min_ones + 4'd1;
      end
    end
  end

  // Count registers; these are the BCD outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else begin
      sec_ones <= w_sec_ones_nxt;
      sec_tens <= w_sec_tens_nxt;
      min_ones <= w_min_ones_nxt;
      min_tens <= w_min_tens_nxt;
    end
  end

  // Only the field under adjustment blinks; normal mode never blanks.
  always_comb begin
    w_blank_min = adj & blink & ~sel;
    w_blank_sec = adj & blink &  sel;
  end

  // Segment registers, one stage behind the count and tracking blink directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_min_top <= C_SEG_ZERO;
      seg_min_bot <= C_SEG_ZERO;
      seg_sec_top <= C_SEG_ZERO;
      seg_sec_bot <= C_SEG_ZERO;
    end else begin
      seg_min_top <= w_blank_min ? C_SEG_BLANK : seg_encode(min_tens);
      seg_min_bot <= w_blank_min ? C_SEG_BLANK : seg_encode(min_ones);
      seg_sec_top <= w_blank_sec ? C_SEG_BLANK : seg_encode(sec_tens);
      seg_sec_bot <= w_blank_sec ? C_SEG_BLANK : seg_encode(sec_ones);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_core
//  Purpose  : Self-checking bench for stopwatch_core; directed scenarios plus
//             randomized traffic against a minutes/seconds arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       blink = 1'b0;
  logic       pause = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] seg_min_top, seg_min_bot, seg_sec_top, seg_sec_bot;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       paused;

  int checks = 0;
  int errors = 0;

  // Reference model: whole minutes/seconds as integers, plus expected segments.
  int          mm = 0;
  int          ss = 0;
  logic        mp = 1'b0;
  logic [31:0] exp_seg = 32'hC0C0C0C0;
  logic [7:0]  seg_tab [0:9];

  stopwatch_core dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .tick_2hz    (tick_2hz),
    .blink       (blink),
    .pause       (pause),
    .adj         (adj),
    .sel         (sel),
    .seg_min_top (seg_min_top),
    .seg_min_bot (seg_min_bot),
    .seg_sec_top (seg_sec_top),
    .seg_sec_bot (seg_sec_bot),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_bcd();
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_bcd();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [31:0] dut_seg();
    return {seg_min_top, seg_min_bot, seg_sec_top, seg_sec_bot};
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input logic t1, input logic t2, input logic ps,
                      input logic ad, input logic sl, input logic bl,
                      input logic rs);
    int tot;
    @(negedge clk);
    tick_1hz = t1; tick_2hz = t2; pause = ps;
    adj = ad; sel = sl; blink = bl; rst = rs;
    if (rs) begin
      mm = 0; ss = 0; mp = 1'b0;
      exp_seg = 32'hC0C0C0C0;
    end else begin
      exp_seg = {(ad && bl && !sl) ? 8'hFF : seg_tab[mm / 10],
                 (ad && bl && !sl) ? 8'hFF : seg_tab[mm % 10],
                 (ad && bl &&  sl) ? 8'hFF : seg_tab[ss / 10],
                 (ad && bl &&  sl) ? 8'hFF : seg_tab[ss % 10]};
      if (!mp) begin
        if (!ad && t1) begin
          tot = (mm * 60 + ss + 1) % 6000;
          mm = tot / 60;
          ss = tot % 60;
        end else if (ad && t2) begin
          if (sl) ss = (ss + 1) % 60;
          else    mm = (mm + 1) % 100;
        end
      end
      if (ps) mp = !mp;
    end
    @(posedge clk);
    #1;
  endtask

  // Use adjust stepping to bring the count to a target (assumes RUN).
  task automatic adjust_to(input int tm, input int ts);
    for (int i = 0; i < 100 && mm != tm; i++) step(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 60 && ss != ts; i++)  step(0, 1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h0000) begin
      errors++; $display("FAIL reset_bcd got %h exp %h", dut_bcd(), 16'h0000);
    end
    checks++;
    if (dut_seg() !== 32'hC0C0C0C0) begin
      errors++; $display("FAIL reset_seg got %h exp %h", dut_seg(), 32'hC0C0C0C0);
    end
    checks++;
    if (paused !== 1'b0) begin
      errors++; $display("FAIL reset_paused got %b exp 0", paused);
    end
  endtask

  task automatic test_run();
    for (int i = 0; i < 61; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      if (i == 60) begin
        checks++;
        if (dut_bcd() !== 16'h0101) begin
          errors++; $display("FAIL run_61_bcd got %h exp %h", dut_bcd(), 16'h0101);
        end
      end
      step(0, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (seg_min_bot !== 8'hF9 || seg_sec_bot !== 8'hF9) begin
      errors++;
      $display("FAIL run_61_seg got min_bot %h sec_bot %h exp F9 F9", seg_min_bot, seg_sec_bot);
    end
  endtask

  task automatic test_full_wrap();
    adjust_to(99, 59);
    checks++;
    if (dut_bcd() !== 16'h9959) begin
      errors++; $display("FAIL wrap_setup got %h exp %h", dut_bcd(), 16'h9959);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h0000) begin
      errors++; $display("FAIL wrap_bcd got %h exp %h", dut_bcd(), 16'h0000);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_seg() !== 32'hC0C0C0C0) begin
      errors++; $display("FAIL wrap_seg got %h exp %h", dut_seg(), 32'hC0C0C0C0);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h0005 || paused !== 1'b1) begin
      errors++; $display("FAIL pause_hold got %h/%b exp 0005/1", dut_bcd(), paused);
    end
    step(1, 0, 1, 0, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h0005 || paused !== 1'b0) begin
      errors++; $display("FAIL pause_resume got %h/%b exp 0005/0", dut_bcd(), paused);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h0006) begin
      errors++; $display("FAIL pause_next_tick got %h exp %h", dut_bcd(), 16'h0006);
    end
    // Running + pause + tick: advances, then freezes.
    step(1, 0, 1, 0, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h0007 || paused !== 1'b1) begin
      errors++; $display("FAIL pause_run_tick got %h/%b exp 0007/1", dut_bcd(), paused);
    end
    step(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_adjust_seconds();
    logic [15:0] want [0:2];
    want[0] = 16'h0359; want[1] = 16'h0300; want[2] = 16'h0301;
    adjust_to(3, 58);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 1, 0, 0);
      checks++;
      if (dut_bcd() !== want[i]) begin
        errors++; $display("FAIL adj_sec_step%0d got %h exp %h", i, dut_bcd(), want[i]);
      end
      step(1, 0, 0, 1, 1, 0, 0);
      checks++;
      if (dut_bcd() !== want[i]) begin
        errors++; $display("FAIL adj_sec_1hz%0d got %h exp %h", i, dut_bcd(), want[i]);
      end
    end
  endtask

  task automatic test_adjust_minutes_blink();
    adjust_to(98, 30);
    step(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h9930) begin
      errors++; $display("FAIL adj_min_99 got %h exp %h", dut_bcd(), 16'h9930);
    end
    step(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h0030) begin
      errors++; $display("FAIL adj_min_wrap got %h exp %h", dut_bcd(), 16'h0030);
    end
    step(0, 0, 0, 1, 0, 1, 0);
    checks++;
    if (dut_seg() !== 32'hFFFFB0C0) begin
      errors++; $display("FAIL blink_on got %h exp %h", dut_seg(), 32'hFFFFB0C0);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (dut_seg() !== 32'hC0C0B0C0) begin
      errors++; $display("FAIL blink_off got %h exp %h", dut_seg(), 32'hC0C0B0C0);
    end
    // Blink in normal mode never blanks.
    step(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (dut_seg() !== 32'hC0C0B0C0) begin
      errors++; $display("FAIL blink_normal got %h exp %h", dut_seg(), 32'hC0C0B0C0);
    end
  endtask

  task automatic test_reset_mid();
    adjust_to(42, 17);
    step(0, 0, 1, 1, 1, 0, 0);
    checks++;
    if (dut_bcd() !== 16'h4217 || paused !== 1'b1) begin
      errors++; $display("FAIL mid_setup got %h/%b exp 4217/1", dut_bcd(), paused);
    end
    step(0, 1, 1, 1, 1, 0, 1);
    checks++;
    if (dut_bcd() !== 16'h0000 || paused !== 1'b0 || dut_seg() !== 32'hC0C0C0C0) begin
      errors++;
      $display("FAIL mid_reset got %h/%b/%h exp 0000/0/C0C0C0C0", dut_bcd(), paused, dut_seg());
    end
  endtask

  task automatic test_random();
    logic ad = 1'b0, sl = 1'b0, bl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) ad = ~ad;
      if ($urandom_range(0, 19) == 0) sl = ~sl;
      if ($urandom_range(0, 7) == 0)  bl = ~bl;
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 24) == 0), ad, sl, bl,
           1'($urandom_range(0, 499) == 0));
      checks++;
      if (dut_bcd() !== model_bcd()) begin
        errors++; $display("FAIL rand_bcd cyc %0d got %h exp %h", i, dut_bcd(), model_bcd());
      end
      checks++;
      if (dut_seg() !== exp_seg) begin
        errors++; $display("FAIL rand_seg cyc %0d got %h exp %h", i, dut_seg(), exp_seg);
      end
      checks++;
      if (paused !== mp) begin
        errors++; $display("FAIL rand_paused cyc %0d got %b exp %b", i, paused, mp);
      end
    end
  endtask

  initial begin
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
    seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
    test_reset();
    test_run();
    test_full_wrap();
    test_pause();
    test_adjust_seconds();
    test_adjust_minutes_blink();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
